skid_reg: RTL and testbench
===========================

# skid_reg

- Two-entry valid/ready pipeline register (skid buffer) with a Bluespec FIFO-style ENQ/DEQ handshake.
- Sits directly upstream of the plain enabled state register in the datapath library:
  - Accepts a word from a producer.
  - Holds it until the consumer's load enable (DEQ) takes it.
  - Keeps full one-word-per-cycle throughput with all handshake outputs registered.
- Uses one clock and a synchronous, active-high reset.

## Interface
- `width`, default 1: data width in bits.
- `init`, default all zeros: reset value of both data entries, and therefore of D_OUT.

- `CLK` input 1: clock, rising edge.
- `RST` input 1: synchronous, active-high reset. Fixed polarity, independent of `BSV_POSITIVE_RESET`.
- `ENQ` input 1: producer writes D_IN this cycle. Legal only when FULL_N=1.
- `D_IN` input `width`: enqueue data.
- `FULL_N` output 1: registered. 1 when fewer than 2 entries are held.
- `DEQ` input 1: consumer takes D_OUT this cycle. Legal only when EMPTY_N=1.
- `D_OUT` output `width`: head entry, driven directly from a register.
- `EMPTY_N` output 1: registered. 1 when at least 1 entry is held.
- `CLR` input 1: synchronous flush. Present only with `SKID_REG_CLEAR_EN`.

## Operation
- Storage:
  - Head register `main`, which drives D_OUT.
  - Overflow register `skid`.
  - 2-bit state: EMPTY, ONE, TWO.
- Effective strobes: `enq = ENQ & FULL_N`; `deq = DEQ & EMPTY_N`.
- State EMPTY:
  - enq: main<=D_IN, go to ONE.
  - DEQ is ignored.
- State ONE:
  - enq&deq: main<=D_IN, stay in ONE.
  - enq only: skid<=D_IN, go to TWO.
  - deq only: go to EMPTY.
  - Neither: hold.
- State TWO:
  - deq: main<=skid, go to ONE.
  - ENQ is ignored because FULL_N=0.
- Flags:
  - FULL_N = (state != TWO).
  - EMPTY_N = (state != EMPTY).
  - Both are decoded from registered state, with no input-to-output combinational path.
- Order is strict FIFO. No entry is ever dropped or duplicated under legal use.
- Illegal use: ENQ while FULL_N=0, or DEQ while EMPTY_N=0.
  - The strobe is ignored and no state changes.
  - Simulation-only checking code (translate_off) prints a warning naming the instance (%m).
- Data registers change only on the writes listed above. A dequeue from ONE to EMPTY leaves main unchanged, so D_OUT holds a stale but stable value.

## Timing
- Reset, evaluated on the CLK edge with RST=1:
  - state=EMPTY, so EMPTY_N=0 and FULL_N=1.
  - main=skid=`init`, so D_OUT=`init`.
- RST overrides ENQ, DEQ and CLR in the same cycle.
- Reset mid-operation discards both entries.
- Latency: a word enqueued at edge n appears on D_OUT with EMPTY_N=1 after edge n.
- Throughput: one transfer per cycle in steady state with ENQ and DEQ both held high.
- FULL_N falls one cycle after the second back-to-back enqueue with no dequeue.
- FULL_N rises the cycle after a dequeue from TWO.
- Simultaneous enq&deq in ONE keeps the occupancy constant; the new word is on D_OUT next cycle.
- Before the first write after reset, X on D_IN must not reach D_OUT.

## Configuration
- Macro `SKID_REG_CLEAR_EN`.
- Defined:
  - The CLR port exists.
  - CLR=1 at an edge forces state=EMPTY (EMPTY_N=0, FULL_N=1) next cycle.
  - CLR overrides ENQ and DEQ in that cycle.
  - Data registers are not written, so D_OUT holds its last value.
- Undefined:
  - No CLR port and no flush logic.
  - The only way to empty the block is dequeueing or RST.

## Test plan
- Reset: RST=1 for 2 cycles with ENQ=1, D_IN=8'hAA, width=8, init=8'h5A -> after release EMPTY_N=0, FULL_N=1, D_OUT=8'h5A.
- Streaming: ENQ=1 and DEQ=1 every cycle after the first, D_IN=1,2,3...100 -> D_OUT sequence 1..100 in order, one per cycle, FULL_N stays 1.
- Backpressure: enqueue 8'h11, then 8'h22 with DEQ=0 -> FULL_N=0 with D_OUT=8'h11. A further ENQ of 8'h33 is ignored and raises a warning. Then DEQ twice -> D_OUT=8'h22, then EMPTY_N=0.
- Empty dequeue: DEQ=1 from EMPTY -> no state change, warning printed, FULL_N=1, EMPTY_N=0.
- Mid-operation reset: in state TWO assert RST with ENQ=DEQ=1 -> next cycle EMPTY_N=0, FULL_N=1, D_OUT=`init`.
- Clear (only with `SKID_REG_CLEAR_EN` defined): in TWO holding 8'h11/8'h22, pulse CLR with ENQ=1 -> next cycle EMPTY_N=0, FULL_N=1, D_OUT=8'h11. A subsequent enqueue of 8'h44 -> D_OUT=8'h44.

Source files
------------

// File: rtl/skid_reg.sv
// Two-entry valid/ready skid buffer with a FIFO-style ENQ/DEQ handshake and registered flags.
// Optional synchronous flush port CLR is enabled by defining SKID_REG_CLEAR_EN.
module skid_reg #(
  parameter int               width = 1,
  parameter logic [width-1:0] init  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic [width-1:0] D_IN,
  output logic             FULL_N,
  input  logic             DEQ,
  output logic [width-1:0] D_OUT,
`ifdef SKID_REG_CLEAR_EN
  input  logic             CLR,
`endif
  output logic             EMPTY_N
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [width-1:0]   main_reg, skid_reg_q;
  logic               full_n_reg, empty_n_reg;

  logic               enq, deq;
  logic               main_we, main_from_skid, skid_we;
  logic [width-1:0]   main_next;

  // Strobes are qualified by the registered flags so illegal requests are no-ops.
  assign enq = ENQ & full_n_reg;
  assign deq = DEQ & empty_n_reg;

  always_comb begin
    state_next     = state_reg;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;

    unique case (state_reg)
      ST_EMPTY: begin
        if (enq) begin
          main_we    = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (enq && deq) begin
          main_we = 1'b1;
        end else if (enq) begin
          skid_we    = 1'b1;
          state_next = ST_TWO;
        end else if (deq) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deq) begin
          main_we        = 1'b1;
          main_from_skid = 1'b1;
          state_next     = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase

`ifdef SKID_REG_CLEAR_EN
    // Flush drops occupancy only; the data registers keep their contents.
    if (CLR) begin
      state_next = ST_EMPTY;
      main_we    = 1'b0;
      skid_we    = 1'b0;
    end
`endif
  end

  assign main_next = main_from_skid ? skid_reg_q : D_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_EMPTY;
      full_n_reg  <= 1'b1;
      empty_n_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      full_n_reg  <= (state_next != ST_TWO);
      empty_n_reg <= (state_next != ST_EMPTY);
    end
  end

  // Data registers load only on explicit writes, so X on D_IN never leaks before the first enq.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_reg   <= init;
      skid_reg_q <= init;
    end else begin
      if (main_we) begin
        main_reg <= main_next;
      end
      if (skid_we) begin
        skid_reg_q <= D_IN;
      end
    end
  end

  assign FULL_N  = full_n_reg;
  assign EMPTY_N = empty_n_reg;
  assign D_OUT   = main_reg;

`ifndef SYNTHESIS
  logic clr_active;
`ifdef SKID_REG_CLEAR_EN
  assign clr_active = CLR;
`else
  assign clr_active = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST && !clr_active) begin
      if (ENQ && !full_n_reg) begin
        $warning("%m: ENQ while FULL_N=0 ignored");
      end
      if (DEQ && !empty_n_reg) begin
        $warning("%m: DEQ while EMPTY_N=0 ignored");
      end
    end
    if (!RST) begin
      assert (full_n_reg == (state_reg != ST_TWO) && empty_n_reg == (state_reg != ST_EMPTY))
        else $error("%m: flag registers disagree with state");
    end
  end
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Randomized and directed bench for skid_reg; a queue model predicts flags and D_OUT every cycle.
module tb_skid_reg;

  localparam int         W    = 8;
  localparam logic [7:0] INIT = 8'h5A;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ENQ;
  logic [W-1:0] D_IN;
  logic         FULL_N;
  logic         DEQ;
  logic [W-1:0] D_OUT;
  logic         EMPTY_N;
  logic         clr_drv;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_head;

  always #5 CLK = ~CLK;

  skid_reg #(.width(W), .init(INIT)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ENQ    (ENQ),
    .D_IN   (D_IN),
    .FULL_N (FULL_N),
    .DEQ    (DEQ),
    .D_OUT  (D_OUT),
`ifdef SKID_REG_CLEAR_EN
    .CLR    (clr_drv),
`endif
    .EMPTY_N(EMPTY_N)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the queue model, then compare all outputs.
  task automatic step(input logic rst, input logic enq, input logic [7:0] din,
                      input logic deq, input logic clr, input string tag);
    bit enq_ok, deq_ok;
    RST     = rst;
    ENQ     = enq;
    D_IN    = din;
    DEQ     = deq;
    clr_drv = clr;
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      model_head = INIT;
    end else if (clr) begin
      model_q.delete();
    end else begin
      enq_ok = enq && (model_q.size() < 2);
      deq_ok = deq && (model_q.size() > 0);
      if (deq_ok) void'(model_q.pop_front());
      if (enq_ok) model_q.push_back(din);
    end
    if (model_q.size() > 0) model_head = model_q[0];
    #1;
    check({tag, ".full_n"},  32'(FULL_N),  32'(model_q.size() < 2));
    check({tag, ".empty_n"}, 32'(EMPTY_N), 32'(model_q.size() > 0));
    check({tag, ".d_out"},   32'(D_OUT),   32'(model_head));
    $display("txn %-10s rst=%0b enq=%0b deq=%0b din=%h -> full_n=%0b empty_n=%0b d_out=%h",
             tag, rst, enq, deq, din, FULL_N, EMPTY_N, D_OUT);
  endtask

  initial begin
    RST = 1'b1; ENQ = 1'b0; DEQ = 1'b0; D_IN = '0; clr_drv = 1'b0;
    model_head = INIT;

    // Reset with an enqueue attempt in flight
    step(1, 1, 8'hAA, 0, 0, "reset");
    step(1, 1, 8'hAA, 0, 0, "reset");
    check("rst_dout", 32'(D_OUT), 32'h5A);
    check("rst_empty_n", 32'(EMPTY_N), 32'd0);
    check("rst_full_n", 32'(FULL_N), 32'd1);

    // X on D_IN without ENQ must not reach D_OUT
    step(0, 0, 8'hxx, 0, 0, "xin");
    check("xin_dout", 32'(D_OUT), 32'h5A);

    // Streaming: first cycle enqueue only, then enqueue+dequeue each cycle
    step(0, 1, 8'd1, 0, 0, "stream");
    check("stream_first", 32'(D_OUT), 32'd1);
    for (int i = 2; i <= 100; i++) begin
      step(0, 1, 8'(i), 1, 0, "stream");
      check("stream_seq", 32'(D_OUT), 32'(i));
      check("stream_full_n", 32'(FULL_N), 32'd1);
    end
    step(0, 0, 8'h00, 1, 0, "drain");
    check("drain_empty_n", 32'(EMPTY_N), 32'd0);

    // Backpressure and illegal enqueue
    step(0, 1, 8'h11, 0, 0, "bp");
    step(0, 1, 8'h22, 0, 0, "bp");
    check("bp_full_n", 32'(FULL_N), 32'd0);
    check("bp_dout", 32'(D_OUT), 32'h11);
    step(0, 1, 8'h33, 0, 0, "bp_illegal");
    check("bp_ignored", 32'(D_OUT), 32'h11);
    step(0, 0, 8'h00, 1, 0, "bp_deq");
    check("bp_deq1", 32'(D_OUT), 32'h22);
    check("bp_full_n_rise", 32'(FULL_N), 32'd1);
    step(0, 0, 8'h00, 1, 0, "bp_deq");
    check("bp_deq2_empty", 32'(EMPTY_N), 32'd0);

    // Dequeue from empty is ignored
    step(0, 0, 8'h00, 1, 0, "empty_deq");
    check("edeq_full_n", 32'(FULL_N), 32'd1);
    check("edeq_empty_n", 32'(EMPTY_N), 32'd0);
    check("edeq_stale", 32'(D_OUT), 32'h22);

    // Reset in state TWO with both strobes high
    step(0, 1, 8'h44, 0, 0, "fill");
    step(0, 1, 8'h55, 0, 0, "fill");
    step(1, 1, 8'h66, 1, 0, "mid_rst");
    check("mid_rst_dout", 32'(D_OUT), 32'h5A);
    check("mid_rst_empty_n", 32'(EMPTY_N), 32'd0);
    check("mid_rst_full_n", 32'(FULL_N), 32'd1);

`ifdef SKID_REG_CLEAR_EN
    step(0, 1, 8'h11, 0, 0, "fill");
    step(0, 1, 8'h22, 0, 0, "fill");
    step(0, 1, 8'h77, 0, 1, "clr");
    check("clr_empty_n", 32'(EMPTY_N), 32'd0);
    check("clr_full_n", 32'(FULL_N), 32'd1);
    check("clr_dout", 32'(D_OUT), 32'h11);
    step(0, 1, 8'h44, 0, 0, "post_clr");
    check("post_clr_dout", 32'(D_OUT), 32'h44);
`endif

    // Randomized traffic, mostly legal, with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic       r_rst, r_enq, r_deq, r_clr;
      logic [7:0] r_din;
      r_rst = ($urandom_range(0, 59) == 0);
      r_enq = ($urandom_range(0, 2) != 0);
      r_deq = ($urandom_range(0, 2) != 0);
      if (r_enq && model_q.size() == 2 && $urandom_range(0, 9) != 0) r_enq = 1'b0;
      if (r_deq && model_q.size() == 0 && $urandom_range(0, 9) != 0) r_deq = 1'b0;
`ifdef SKID_REG_CLEAR_EN
      r_clr = ($urandom_range(0, 39) == 0);
`else
      r_clr = 1'b0;
`endif
      r_din = 8'($urandom);
      step(r_rst, r_enq, r_din, r_deq, r_clr, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
